draw_source_arbiter: RTL and testbench
======================================

// Module: draw_source_arbiter
// PURPOSE
//  Frame-level scheduler for the shared draw bus. On each frame pulse it grants sources 0..NUM_SOURCES-1
//  in fixed painter's order: the highest index draws last, on top. For each source it drives
//  write_source_sel and write_awaited, then accepts pixel beats while write_active is high. Accepted
//  opaque, in-bounds pixels are written to the framebuffer port. Sits between the draw sources
//  (starfield and sprite units) and the frame manager.
// PARAMETERS
//  NUM_SOURCES    4     number of draw sources on the shared bus
//  SEL_W          2     write_source_sel width; equals SOURCE_SEL_ADDRW
//  COLOR_DEPTH    9     pixel colour width
//  AWAIT_TIMEOUT  1024  cycles to wait for write_active before skipping a source
//  DRAIN_MAX      4096  maximum beats per grant before a forced abort
// PORTS
//  clk                input   1            system clock
//  resetN             input   1            async active-low reset
//  frame              input   1            1-cycle pulse at frame start; requests one draw pass
//  source_en          input   NUM_SOURCES  per-source enable; disabled sources are skipped
//  write_source_sel   output  SEL_W        index of the currently granted source
//  write_awaited      output  1            grant strobe to the selected source
//  write_active       input   1            selected source is presenting a pixel beat
//  write_color_data   input   COLOR_DEPTH  beat colour
//  write_transparent  input   1            beat is not to be written
//  write_x_addr       input   32           beat x, signed
//  write_y_addr       input   32           beat y, signed
//  fb_we              output  1            framebuffer write strobe
//  fb_addr            output  19           y*DRAW_WIDTH + x
//  fb_data            output  COLOR_DEPTH  colour to write
//  pass_busy          output  1            a draw pass is in progress
//  pass_done          output  1            1-cycle pulse when a pass ends
//  timeout_err        output  1            sticky: some source never answered its grant
//  overrun_err        output  1            sticky: frame pulse arrived while pass_busy, or a drain hit DRAIN_MAX
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; src=0; frame_pending=0. Reset mid-pass aborts immediately;
//   write_awaited falls asynchronously. Sticky flags clear only on reset.
//  frame_pending is set by frame and cleared on the IDLE->SELECT transition. If frame arrives in the
//   same cycle as that transition, frame_pending stays set. Frame while pass_busy sets frame_pending
//   and overrun_err; at most one pass is queued.
//  FSM states: IDLE, SELECT, AWAIT, DRAIN, NEXT. All outputs are registered.
//   IDLE: frame_pending -> SELECT; src=0; pass_busy=1.
//   SELECT: write_source_sel<=src; source_en[src] ? AWAIT with timer=0 : NEXT.
//   AWAIT: write_awaited=1. If write_active -> DRAIN (that cycle counts as a beat).
//    Else if timer==AWAIT_TIMEOUT-1 -> timeout_err=1, go to NEXT. Else timer++.
//   DRAIN: write_awaited=0. While write_active, accept one beat per cycle; beat count++.
//    write_active=0 -> NEXT. Beat count==DRAIN_MAX -> overrun_err=1, go to NEXT.
//   NEXT: if src==NUM_SOURCES-1 -> pass_done=1, pass_busy=0, go to IDLE. Else src++ -> SELECT.
//  Beat: a cycle in AWAIT or DRAIN with write_active===1. X/Z on write_active counts as 0. The bus
//   floats outside grants, so write_active is ignored in IDLE, SELECT and NEXT.
//  Beat filter: write when !transparent && 0<=x<DRAW_WIDTH && 0<=y<DRAW_HEIGHT, with x and y treated
//   as signed 32-bit. Otherwise drop silently.
//  fb_we, fb_addr and fb_data appear one cycle after the beat. fb_we=0 on dropped beats and in all
//   other cycles.
//  write_source_sel holds its last value while IDLE; write_awaited=0 makes that harmless.
// STRUCTURE
//  Shared package draw_mgr_pkg: DRAW_WIDTH=640, DRAW_HEIGHT=480, FB_ADDRW=19, arb_state_t enum.
//  Sub-module draw_pixel_filter: registered bounds check, transparency gating and address multiply-add.
//   The FSM, counters and error flags live in the top module.
// TESTING
//  1. 2 sources, both enabled; src0 gives 3 beats at (0,0),(639,479),(10,5) -> fb_addr 0,307199,3210;
//     pass_done fires once.
//  2. Beats with x=-1, x=640, y=480, transparent=1 -> no fb_we; the beat counter still advances.
//  3. source_en=2'b01; src1 responds -> src1 never sees write_awaited; pass_done 3 cycles after src0 drain ends.
//  4. Silent source, AWAIT_TIMEOUT=8 -> awaited high 8 cycles, timeout_err=1, next source granted.
//  5. Second frame pulse mid-pass -> overrun_err=1; exactly one further pass runs after pass_done.
//  6. resetN low during DRAIN -> all outputs 0 at once; after release, IDLE until the next frame.

Source files
------------

// File: rtl/draw_mgr_pkg.sv
// +--------------------------------------------------------------------+
// | draw_mgr_pkg: framebuffer geometry, arbiter states, bounds helper  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package draw_mgr_pkg;

  localparam int DRAW_WIDTH  = 640;
  localparam int DRAW_HEIGHT = 480;
  localparam int FB_ADDRW    = 19;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SELECT = 3'd1;
  localparam logic [2:0] ST_AWAIT  = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_NEXT   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_SELECT = ST_SELECT,
    S_AWAIT  = ST_AWAIT,
    S_DRAIN  = ST_DRAIN,
    S_NEXT   = ST_NEXT
  } arb_state_t;

  function automatic logic in_frame(input logic signed [31:0] x, input logic signed [31:0] y);
    return (x >= 0) && (x < DRAW_WIDTH) && (y >= 0) && (y < DRAW_HEIGHT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/draw_pixel_filter.sv
// +--------------------------------------------------------------------+
// | draw_pixel_filter: drops transparent/off-screen beats, registers   |
// | the framebuffer write. Rev 1.0                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module draw_pixel_filter
  import draw_mgr_pkg::*;
#(
  parameter int COLOR_DEPTH = 9
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   beat,
  input  logic [COLOR_DEPTH-1:0] color,
  input  logic                   transparent,
  input  logic signed [31:0]     x,
  input  logic signed [31:0]     y,
  output logic                   fb_we,
  output logic [FB_ADDRW-1:0]    fb_addr,
  output logic [COLOR_DEPTH-1:0] fb_data
);

  logic                   fb_we_q,   fb_we_d;
  logic [FB_ADDRW-1:0]    fb_addr_q, fb_addr_d;
  logic [COLOR_DEPTH-1:0] fb_data_q, fb_data_d;

  always_comb begin
    fb_we_d   = beat && !transparent && in_frame(x, y);
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;
    // Bounds already hold, so the 19-bit truncation of the product is exact.
    if (fb_we_d) begin
      fb_addr_d = y[FB_ADDRW-1:0] * FB_ADDRW'(DRAW_WIDTH) + x[FB_ADDRW-1:0];
      fb_data_d = color;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      fb_we_q   <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
    end else begin
      fb_we_q   <= fb_we_d;
      fb_addr_q <= fb_addr_d;
      fb_data_q <= fb_data_d;
    end
  end

  assign fb_we   = fb_we_q;
  assign fb_addr = fb_addr_q;
  assign fb_data = fb_data_q;

endmodule

`default_nettype wire

// File: rtl/draw_source_arbiter.sv
// +--------------------------------------------------------------------+
// | draw_source_arbiter: per-frame painter's-order grant of the shared |
// | draw bus to each source. Rev 1.0                                  |
// +--------------------------------------------------------------------+
`default_nettype none

module draw_source_arbiter
  import draw_mgr_pkg::*;
#(
  parameter int NUM_SOURCES   = 4,
  parameter int SEL_W         = 2,
  parameter int COLOR_DEPTH   = 9,
  parameter int AWAIT_TIMEOUT = 1024,
  parameter int DRAIN_MAX     = 4096
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   frame,
  input  logic [NUM_SOURCES-1:0] source_en,
  output logic [SEL_W-1:0]       write_source_sel,
  output logic                   write_awaited,
  input  logic                   write_active,
  input  logic [COLOR_DEPTH-1:0] write_color_data,
  input  logic                   write_transparent,
  input  logic [31:0]            write_x_addr,
  input  logic [31:0]            write_y_addr,
  output logic                   fb_we,
  output logic [FB_ADDRW-1:0]    fb_addr,
  output logic [COLOR_DEPTH-1:0] fb_data,
  output logic                   pass_busy,
  output logic                   pass_done,
  output logic                   timeout_err,
  output logic                   overrun_err
);

  localparam int TMR_W = $clog2(AWAIT_TIMEOUT + 1);
  localparam int CNT_W = $clog2(DRAIN_MAX + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(AWAIT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DRAIN_MAX);
  localparam logic [SEL_W-1:0] SRC_LAST = SEL_W'(NUM_SOURCES - 1);

  arb_state_t       state_q, state_d;
  logic [SEL_W-1:0] src_q, src_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             awaited_q, awaited_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             overrun_q, overrun_d;
  logic             w_active;
  logic             w_beat;

  // The bus floats outside grants; anything but a clean 1 is no beat.
  assign w_active = (write_active === 1'b1);
  // A beat offered once DRAIN_MAX are taken is the abort trigger, not data.
  assign w_beat = w_active && ((state_q == S_AWAIT) ||
                               ((state_q == S_DRAIN) && (cnt_q != CNT_MAX)));

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    sel_d     = sel_q;
    timer_d   = timer_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    timeout_d = timeout_q;
    overrun_d = overrun_q;
    pending_d = pending_q | frame;
    if (frame && busy_q) overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          state_d   = S_SELECT;
          src_d     = '0;
          pending_d = frame;
        end
      end
      S_SELECT: begin
        sel_d   = src_q;
        timer_d = '0;
        state_d = source_en[src_q] ? S_AWAIT : S_NEXT;
      end
      S_AWAIT: begin
        if (w_active) begin
          state_d = S_DRAIN;
          cnt_d   = CNT_W'(1);
        end else if (timer_q == TMR_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_NEXT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (!w_active) begin
          state_d = S_NEXT;
        end else if (cnt_q == CNT_MAX) begin
          overrun_d = 1'b1;
          state_d   = S_NEXT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_NEXT: begin
        if (src_q == SRC_LAST) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          src_d   = src_q + 1'b1;
          state_d = S_SELECT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    awaited_d = (state_d == S_AWAIT);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      sel_q     <= '0;
      timer_q   <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      awaited_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      sel_q     <= sel_d;
      timer_q   <= timer_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      awaited_q <= awaited_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end

  draw_pixel_filter #(
    .COLOR_DEPTH(COLOR_DEPTH)
  ) u_filter (
    .clk        (clk),
    .resetN     (resetN),
    .beat       (w_beat),
    .color      (write_color_data),
    .transparent(write_transparent),
    .x          (write_x_addr),
    .y          (write_y_addr),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data)
  );

  assign write_source_sel = sel_q;
  assign write_awaited    = awaited_q;
  assign pass_busy        = busy_q;
  assign pass_done        = done_q;
  assign timeout_err      = timeout_q;
  assign overrun_err      = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_draw_source_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_draw_source_arbiter: directed stimulus, scoreboarded fb writes  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_draw_source_arbiter;

  localparam int NS = 2;
  localparam int SW = 1;
  localparam int CD = 9;
  localparam int AT = 8;
  localparam int DM = 6;

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic          frame = 1'b0;
  logic [NS-1:0] source_en = '0;
  logic          write_active = 1'b0;
  logic [CD-1:0] write_color_data = '0;
  logic          write_transparent = 1'b0;
  logic [31:0]   write_x_addr = '0;
  logic [31:0]   write_y_addr = '0;
  logic [SW-1:0] write_source_sel;
  logic          write_awaited;
  logic          fb_we;
  logic [18:0]   fb_addr;
  logic [CD-1:0] fb_data;
  logic          pass_busy;
  logic          pass_done;
  logic          timeout_err;
  logic          overrun_err;

  int          n_tests = 0;
  int          n_fail = 0;
  int          pass_done_cnt = 0;
  bit          forbid_sel1 = 1'b0;
  logic [27:0] exp_q[$];
  logic [27:0] mon_e;

  draw_source_arbiter #(
    .NUM_SOURCES(NS), .SEL_W(SW), .COLOR_DEPTH(CD),
    .AWAIT_TIMEOUT(AT), .DRAIN_MAX(DM)
  ) dut (
    .clk(clk), .resetN(resetN), .frame(frame), .source_en(source_en),
    .write_source_sel(write_source_sel), .write_awaited(write_awaited),
    .write_active(write_active), .write_color_data(write_color_data),
    .write_transparent(write_transparent), .write_x_addr(write_x_addr),
    .write_y_addr(write_y_addr), .fb_we(fb_we), .fb_addr(fb_addr),
    .fb_data(fb_data), .pass_busy(pass_busy), .pass_done(pass_done),
    .timeout_err(timeout_err), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every framebuffer write must match the oldest expectation.
  always @(negedge clk) begin
    if (fb_we) begin
      if (exp_q.size() == 0) begin
        check("fb_write_expected", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("fb_addr", 32'(fb_addr), 32'(mon_e[27:9]));
        check("fb_data", 32'(fb_data), 32'(mon_e[8:0]));
      end
    end
    if (forbid_sel1 && write_source_sel == 1'b1) check("src1_awaited", 32'(write_awaited), 32'd0);
    if (pass_done) pass_done_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetN = 1'b0; frame = 1'b0; write_active = 1'b0; source_en = '0; forbid_sel1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;
    tick();
  endtask

  task automatic pulse_frame();
    frame = 1'b1;
    tick();
    frame = 1'b0;
  endtask

  task automatic drive_beat(input int x, input int y, input int c, input bit t, input bit we, input int addr);
    write_x_addr = 32'(x);
    write_y_addr = 32'(y);
    write_color_data = CD'(c);
    write_transparent = t;
    write_active = 1'b1;
    if (we) exp_q.push_back({19'(addr), 9'(c)});
    tick();
  endtask

  task automatic end_beats();
    write_active = 1'b0;
    write_transparent = 1'b0;
  endtask

  task automatic wait_awaited(input int s);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (write_awaited && write_source_sel == SW'(s)) ok = 1'b1;
      else tick();
    end
    check($sformatf("grant_src%0d", s), 32'(ok), 32'd1);
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (pass_done) ok = 1'b1;
      else tick();
    end
    check("pass_done_seen", 32'(ok), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fb_we"}, 32'(fb_we), 0);
    check({tag, "_fb_addr"}, 32'(fb_addr), 0);
    check({tag, "_fb_data"}, 32'(fb_data), 0);
    check({tag, "_awaited"}, 32'(write_awaited), 0);
    check({tag, "_sel"}, 32'(write_source_sel), 0);
    check({tag, "_busy"}, 32'(pass_busy), 0);
    check({tag, "_done"}, 32'(pass_done), 0);
    check({tag, "_timeout"}, 32'(timeout_err), 0);
    check({tag, "_overrun"}, 32'(overrun_err), 0);
  endtask

  initial begin
    int base;
    int cyc;
    int cnt;

    // Reset state
    resetN = 1'b0;
    tick(); tick();
    check_all_zero("reset");
    resetN = 1'b1;
    tick();

    // 1: two enabled sources, in-bounds beats
    source_en = 2'b11;
    base = pass_done_cnt;
    pulse_frame();
    wait_awaited(0);
    drive_beat(0, 0, 1, 0, 1, 0);
    drive_beat(639, 479, 2, 0, 1, 307199);
    drive_beat(10, 5, 3, 0, 1, 3210);
    end_beats();
    wait_awaited(1);
    drive_beat(1, 1, 4, 0, 1, 641);
    end_beats();
    wait_done();
    repeat (5) tick();
    check("t1_pass_count", 32'(pass_done_cnt - base), 1);
    check("t1_timeout", 32'(timeout_err), 0);
    check("t1_overrun", 32'(overrun_err), 0);
    check("t1_busy", 32'(pass_busy), 0);
    check("t1_sb_empty", 32'(exp_q.size()), 0);

    // 2: dropped beats still count toward DRAIN_MAX
    do_reset();
    source_en = 2'b01;
    forbid_sel1 = 1'b1;
    pulse_frame();
    wait_awaited(0);
    drive_beat(-1, 0, 5, 0, 0, 0);
    drive_beat(640, 0, 5, 0, 0, 0);
    drive_beat(0, 480, 5, 0, 0, 0);
    drive_beat(5, 5, 6, 1, 0, 0);
    drive_beat(2, 0, 7, 0, 1, 2);
    drive_beat(0, 1, 8, 0, 1, 640);
    drive_beat(3, 0, 9, 0, 0, 0);
    end_beats();
    wait_done();
    repeat (3) tick();
    check("t2_overrun", 32'(overrun_err), 1);
    check("t2_timeout", 32'(timeout_err), 0);
    check("t2_sb_empty", 32'(exp_q.size()), 0);

    // 3: disabled src1 is skipped even while the bus claims activity
    do_reset();
    source_en = 2'b01;
    forbid_sel1 = 1'b1;
    pulse_frame();
    wait_awaited(0);
    drive_beat(4, 2, 10, 0, 1, 1284);
    drive_beat(5, 2, 11, 0, 1, 1285);
    write_active = 1'b0;
    tick();
    write_x_addr = 32'd6;
    write_active = 1'b1;
    cyc = 1;
    while (!pass_done && cyc < 20) begin
      tick();
      cyc++;
    end
    end_beats();
    check("t3_done_latency", 32'(cyc), 4);
    repeat (3) tick();
    check("t3_sb_empty", 32'(exp_q.size()), 0);
    forbid_sel1 = 1'b0;

    // 4: silent source times out, next source is granted
    do_reset();
    source_en = 2'b11;
    pulse_frame();
    wait_awaited(0);
    cnt = 0;
    while (write_awaited && cnt < 50) begin
      cnt++;
      tick();
    end
    check("t4_await_cycles", 32'(cnt), AT);
    check("t4_timeout", 32'(timeout_err), 1);
    wait_awaited(1);
    drive_beat(7, 0, 12, 0, 1, 7);
    end_beats();
    wait_done();

    // 5: frame during a pass queues exactly one more pass
    do_reset();
    source_en = 2'b01;
    base = pass_done_cnt;
    pulse_frame();
    wait_awaited(0);
    frame = 1'b1;
    drive_beat(1, 0, 13, 0, 1, 1);
    frame = 1'b0;
    drive_beat(2, 0, 14, 0, 1, 2);
    end_beats();
    wait_done();
    check("t5_overrun", 32'(overrun_err), 1);
    wait_awaited(0);
    drive_beat(3, 0, 15, 0, 1, 3);
    end_beats();
    wait_done();
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (write_awaited) cnt++;
    end
    check("t5_no_third_pass", 32'(cnt), 0);
    check("t5_pass_count", 32'(pass_done_cnt - base), 2);

    // 6: asynchronous reset in the middle of a drain
    do_reset();
    source_en = 2'b01;
    pulse_frame();
    wait_awaited(0);
    drive_beat(8, 0, 16, 0, 1, 8);
    drive_beat(9, 0, 17, 0, 1, 9);
    drive_beat(10, 0, 18, 1, 0, 0);
    #2 resetN = 1'b0;
    #1;
    check_all_zero("midreset");
    write_active = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (write_awaited || pass_busy) cnt++;
    end
    check("t6_idle_after_reset", 32'(cnt), 0);
    pulse_frame();
    wait_awaited(0);
    drive_beat(11, 0, 19, 0, 1, 11);
    end_beats();
    wait_done();

    repeat (5) tick();
    check("final_sb_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
